// File: rtl/ctr_mc.sv
// ctr_mc: multicycle fetch/decode/execute controller for the accumulator
// datapath. Memory states wait on MemReady, with an optional timeout that
// traps to a terminal state. HALT and TRAP stay put until reset.
module ctr_mc #(
  parameter int OPW        = 8,
  parameter int ALUW       = 2,
  parameter int WAIT_LIMIT = 0,
  parameter int OP_ADD     = 1,
  parameter int OP_OR      = 2,
  parameter int OP_JUMP    = 3,
  parameter int OP_JUMPZ   = 4,
  parameter int OP_LOAD    = 5,
  parameter int OP_STORE   = 6,
  parameter int OP_MULL    = 9,
  parameter int OP_NEG     = 10,
  parameter int OP_HALT    = 15
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Zflag,
  input  logic [OPW-1:0]  opcode,
  input  logic            MemReady,
  output logic            muxPC,
  output logic            muxMAR,
  output logic            muxACC,
  output logic            loadMAR,
  output logic            loadPC,
  output logic            loadACC,
  output logic            loadMDR,
  output logic            loadIR,
  output logic [ALUW-1:0] opALU,
  output logic            MemRW,
  output logic            MemReq,
  output logic            InstrDone,
  output logic            Halted,
  output logic [1:0]      TrapCause,
  output logic [3:0]      state
);

  localparam logic [3:0] S_FETCH1 = 4'd0;
  localparam logic [3:0] S_FETCH2 = 4'd1;
  localparam logic [3:0] S_FETCH3 = 4'd2;
  localparam logic [3:0] S_DECODE = 4'd3;
  localparam logic [3:0] S_EXEC1  = 4'd4;
  localparam logic [3:0] S_EXEC2  = 4'd5;
  localparam logic [3:0] S_STORE  = 4'd6;
  localparam logic [3:0] S_JUMP   = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;
  localparam logic [3:0] S_TRAP   = 4'd9;

  // Operation class of the instruction in flight, used only by EXEC2.
  localparam logic [2:0] CL_OR   = 3'd0;
  localparam logic [2:0] CL_ADD  = 3'd1;
  localparam logic [2:0] CL_MULL = 3'd2;
  localparam logic [2:0] CL_NEG  = 3'd3;
  localparam logic [2:0] CL_LOAD = 3'd4;

  localparam logic [OPW-1:0] C_ADD   = OPW'(OP_ADD);
  localparam logic [OPW-1:0] C_OR    = OPW'(OP_OR);
  localparam logic [OPW-1:0] C_JUMP  = OPW'(OP_JUMP);
  localparam logic [OPW-1:0] C_JUMPZ = OPW'(OP_JUMPZ);
  localparam logic [OPW-1:0] C_LOAD  = OPW'(OP_LOAD);
  localparam logic [OPW-1:0] C_STORE = OPW'(OP_STORE);
  localparam logic [OPW-1:0] C_MULL  = OPW'(OP_MULL);
  localparam logic [OPW-1:0] C_NEG   = OPW'(OP_NEG);
  localparam logic [OPW-1:0] C_HALT  = OPW'(OP_HALT);

  // Wait counter only has to reach WAIT_LIMIT; it saturates so an unlimited
  // wait never wraps.
  localparam int            CW       = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_LIMIT);

  logic [3:0]    state_q, state_d;
  logic [2:0]    cls_q, cls_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [1:0]    tc_q, tc_d;
  logic [1:0]    cause;
  logic          retire;
  logic          mem_req;
  logic          timeout;
  logic [1:0]    alu_sel;

  assign mem_req = (state_q == S_FETCH2) || (state_q == S_EXEC1) || (state_q == S_STORE);
  assign timeout = (WAIT_LIMIT > 0) && mem_req && !MemReady && (wait_q == WAIT_LIM);

  // Next-state, op-class latch, retire pulse and trap cause selection.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cause   = 2'b00;
    retire  = 1'b0;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: begin
        if (timeout) begin
          state_d = S_TRAP;
          cause   = 2'b10;
        end else if (MemReady) begin
          state_d = S_FETCH3;
        end
      end
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == C_ADD) begin
          cls_d = CL_ADD;  state_d = S_EXEC1;
        end else if (opcode == C_OR) begin
          cls_d = CL_OR;   state_d = S_EXEC1;
        end else if (opcode == C_MULL) begin
          cls_d = CL_MULL; state_d = S_EXEC1;
        end else if (opcode == C_NEG) begin
          cls_d = CL_NEG;  state_d = S_EXEC1;
        end else if (opcode == C_LOAD) begin
          cls_d = CL_LOAD; state_d = S_EXEC1;
        end else if (opcode == C_STORE) begin
          state_d = S_STORE;
        end else if (opcode == C_JUMP) begin
          state_d = S_JUMP;
        end else if (opcode == C_JUMPZ) begin
          if (Zflag) begin
            state_d = S_JUMP;
          end else begin
            state_d = S_FETCH1;
            retire  = 1'b1;
          end
        end else if (opcode == C_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_TRAP;
          cause   = 2'b01;
        end
      end
      S_EXEC1: begin
        if (timeout) begin
          state_d = S_TRAP;
          cause   = 2'b10;
        end else if (MemReady) begin
          state_d = S_EXEC2;
        end
      end
      S_EXEC2: begin
        state_d = S_FETCH1;
        retire  = 1'b1;
      end
      S_STORE: begin
        if (timeout) begin
          state_d = S_TRAP;
          cause   = 2'b10;
        end else if (MemReady) begin
          state_d = S_FETCH1;
          retire  = 1'b1;
        end
      end
      S_JUMP: begin
        state_d = S_FETCH1;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: begin
        state_d = S_TRAP;
        cause   = 2'b01;
      end
    endcase
  end

  // Wait counter and sticky trap cause; the cause is captured only when
  // TRAP is first entered.
  always_comb begin
    wait_d = '0;
    if (mem_req && !MemReady) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
    end
    tc_d = tc_q;
    if ((state_d == S_TRAP) && (state_q != S_TRAP) && (tc_q == 2'b00)) begin
      tc_d = cause;
    end
  end

  // ALU select from the latched op-class.
  always_comb begin
    case (cls_q)
      CL_ADD:  alu_sel = 2'd1;
      CL_MULL: alu_sel = 2'd2;
      CL_NEG:  alu_sel = 2'd3;
      default: alu_sel = 2'd0;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_FETCH1;
      cls_q   <= CL_OR;
      wait_q  <= '0;
      tc_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      tc_q    <= tc_d;
    end
  end

  // Datapath control decode; everything is forced low while in reset.
  always_comb begin
    muxPC     = 1'b0;
    muxMAR    = 1'b0;
    muxACC    = 1'b0;
    loadMAR   = 1'b0;
    loadPC    = 1'b0;
    loadACC   = 1'b0;
    loadMDR   = 1'b0;
    loadIR    = 1'b0;
    opALU     = '0;
    MemRW     = 1'b0;
    MemReq    = 1'b0;
    InstrDone = 1'b0;
    Halted    = 1'b0;
    if (Rst) begin
      case (state_q)
        S_FETCH1: begin loadMAR = 1'b1; loadPC = 1'b1; end
        S_FETCH2: begin MemReq = 1'b1; loadMDR = MemReady; end
        S_FETCH3: loadIR = 1'b1;
        S_DECODE: begin muxMAR = 1'b1; loadMAR = 1'b1; end
        S_EXEC1:  begin MemReq = 1'b1; loadMDR = MemReady; end
        S_EXEC2: begin
          loadACC = 1'b1;
          muxACC  = (cls_q == CL_LOAD);
          opALU   = ALUW'(alu_sel);
        end
        S_STORE:  begin MemReq = 1'b1; MemRW = 1'b1; end
        S_JUMP:   begin muxPC = 1'b1; loadPC = 1'b1; end
        S_HALT:   Halted = 1'b1;
        default:  ;
      endcase
      InstrDone = retire;
    end
  end

  assign TrapCause = tc_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ctr_mc.sv
// Testbench for ctr_mc: two instances (no wait limit / wait limit 4) share
// stimulus; each instruction is expanded into its expected per-cycle trace.
module tb_ctr_mc;

  typedef struct packed {
    logic [3:0] st;
    logic mpc, mmar, macc, lmar, lpc, lacc, lmdr, lir;
    logic [1:0] alu;
    logic rw, req, done, halt;
    logic [1:0] tc;
  } obs_t;

  typedef struct packed {
    logic       rdy;
    logic [7:0] op;
    logic       z;
    obs_t       ex;
  } ent_t;

  localparam logic [3:0] F1 = 4'd0, F2 = 4'd1, F3 = 4'd2, DEC = 4'd3, EX1 = 4'd4;
  localparam logic [3:0] EX2 = 4'd5, STO = 4'd6, JMP = 4'd7, HLT = 4'd8, TRP = 4'd9;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Zflag;
  logic [7:0] opcode;
  logic       MemReady;

  logic [3:0] st0, st4;
  logic mpc0, mmar0, macc0, lmar0, lpc0, lacc0, lmdr0, lir0, rw0, req0, done0, halt0;
  logic mpc4, mmar4, macc4, lmar4, lpc4, lacc4, lmdr4, lir4, rw4, req4, done4, halt4;
  logic [1:0] alu0, alu4, tc0, tc4;
  obs_t ob0, ob4;

  int         n_tests = 0;
  int         n_fail  = 0;
  ent_t       q[$];
  logic [1:0] tc_m;
  int         mode_m;   // 0 running, 1 halted, 2 trapped
  bit         sel;      // 0 observes the unlimited instance, 1 the limit-4 one

  always #5 Clk = ~Clk;

  ctr_mc #(.WAIT_LIMIT(0)) u0 (
    .Clk(Clk), .Rst(Rst), .Zflag(Zflag), .opcode(opcode), .MemReady(MemReady),
    .muxPC(mpc0), .muxMAR(mmar0), .muxACC(macc0), .loadMAR(lmar0), .loadPC(lpc0),
    .loadACC(lacc0), .loadMDR(lmdr0), .loadIR(lir0), .opALU(alu0), .MemRW(rw0),
    .MemReq(req0), .InstrDone(done0), .Halted(halt0), .TrapCause(tc0), .state(st0)
  );

  ctr_mc #(.WAIT_LIMIT(4)) u4 (
    .Clk(Clk), .Rst(Rst), .Zflag(Zflag), .opcode(opcode), .MemReady(MemReady),
    .muxPC(mpc4), .muxMAR(mmar4), .muxACC(macc4), .loadMAR(lmar4), .loadPC(lpc4),
    .loadACC(lacc4), .loadMDR(lmdr4), .loadIR(lir4), .opALU(alu4), .MemRW(rw4),
    .MemReq(req4), .InstrDone(done4), .Halted(halt4), .TrapCause(tc4), .state(st4)
  );

  assign ob0 = {st0, mpc0, mmar0, macc0, lmar0, lpc0, lacc0, lmdr0, lir0, alu0, rw0, req0, done0, halt0, tc0};
  assign ob4 = {st4, mpc4, mmar4, macc4, lmar4, lpc4, lacc4, lmdr4, lir4, alu4, rw4, req4, done4, halt4, tc4};

  // ---------------- reference model: instruction -> expected cycle trace
  function automatic obs_t mk(input logic [3:0] s);
    obs_t e;
    e    = '0;
    e.st = s;
    e.tc = tc_m;
    return e;
  endfunction

  task automatic push(input logic r, input logic [7:0] op, input logic z, input obs_t e);
    ent_t en;
    en.rdy = r; en.op = op; en.z = z; en.ex = e;
    q.push_back(en);
  endtask

  task automatic pushx(input obs_t e);
    push(1'($urandom), 8'($urandom), 1'($urandom), e);
  endtask

  task automatic enter_trap(input logic [1:0] c);
    if (tc_m == 2'b00) tc_m = c;
    mode_m = 2;
  endtask

  task automatic push_tail(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = mk((mode_m == 1) ? HLT : TRP);
      if (mode_m == 1) e.halt = 1'b1;
      pushx(e);
    end
  endtask

  // A memory access that takes 'waits' not-ready cycles; it times out when
  // 'limit' consecutive waits have elapsed and the bus is still not ready.
  task automatic mem_phase(input logic [3:0] s, input int waits, input int limit, output bit trapped);
    obs_t e;
    logic r;
    trapped = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      r = (i == waits);
      e = mk(s);
      e.req = 1'b1;
      if (s == STO) begin e.rw = 1'b1; e.done = r; end
      else          e.lmdr = r;
      push(r, 8'($urandom), 1'($urandom), e);
      if (!r && limit > 0 && i == limit) begin
        trapped = 1'b1;
        enter_trap(2'b10);
        break;
      end
    end
  endtask

  task automatic instr(input logic [7:0] op, input logic z, input int w1, input int w2,
                       input int limit, output bit stop);
    obs_t e;
    stop = 1'b0;
    e = mk(F1); e.lmar = 1'b1; e.lpc = 1'b1; pushx(e);
    mem_phase(F2, w1, limit, stop);
    if (stop) return;
    e = mk(F3); e.lir = 1'b1; pushx(e);
    e = mk(DEC); e.mmar = 1'b1; e.lmar = 1'b1;
    e.done = (op == 8'd4) && !z;
    push(1'($urandom), op, z, e);
    case (op)
      8'd1, 8'd2, 8'd5, 8'd9, 8'd10: begin
        mem_phase(EX1, w2, limit, stop);
        if (stop) return;
        e = mk(EX2); e.lacc = 1'b1; e.done = 1'b1;
        e.alu  = (op == 8'd1) ? 2'd1 : (op == 8'd9) ? 2'd2 : (op == 8'd10) ? 2'd3 : 2'd0;
        e.macc = (op == 8'd5);
        pushx(e);
      end
      8'd6: mem_phase(STO, w2, limit, stop);
      8'd3: begin e = mk(JMP); e.mpc = 1'b1; e.lpc = 1'b1; e.done = 1'b1; pushx(e); end
      8'd4: if (z) begin e = mk(JMP); e.mpc = 1'b1; e.lpc = 1'b1; e.done = 1'b1; pushx(e); end
      8'd15: begin mode_m = 1; stop = 1'b1; end
      default: begin enter_trap(2'b01); stop = 1'b1; end
    endcase
  endtask

  // ---------------- stimulus plumbing
  task automatic drive(input ent_t en, output obs_t got);
    @(negedge Clk);
    MemReady = en.rdy;
    opcode   = en.op;
    Zflag    = en.z;
    #1;
    got = sel ? ob4 : ob0;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    q.delete();
    tc_m   = 2'b00;
    mode_m = 0;
    repeat (2) @(posedge Clk);
    #2;
    Rst = 1'b1;
  endtask

  // ---------------- tests
  task automatic test_reset();
    ent_t en; obs_t got; bit stop;
    sel = 1'b0;
    Rst = 1'b0; MemReady = 1'b1; opcode = 8'd1; Zflag = 1'b1;
    #1;
    n_tests++;
    if (ob0 !== '0) begin n_fail++; $display("FAIL reset_u0: got=%h exp=0", ob0); end
    n_tests++;
    if (ob4 !== '0) begin n_fail++; $display("FAIL reset_u4: got=%h exp=0", ob4); end
    do_reset();
    instr(8'd1, 1'b0, 0, 5, 0, stop);
    while (q.size() > 0) begin
      en = q.pop_front(); drive(en, got); n_tests++;
      if (got !== en.ex) begin n_fail++; $display("FAIL reset_pre st=%0d got=%h exp=%h", en.ex.st, got, en.ex); end
      if (en.ex.st == EX1) break;
    end
    q.delete();
    #1; Rst = 1'b0; #1;
    n_tests++;
    if (ob0 !== '0) begin n_fail++; $display("FAIL reset_mid_exec1: got=%h exp=0", ob0); end
    @(posedge Clk); #1;
    n_tests++;
    if (ob0 !== '0) begin n_fail++; $display("FAIL reset_held: got=%h exp=0", ob0); end
    tc_m = 2'b00; mode_m = 0;
    @(posedge Clk); #2; Rst = 1'b1;
    instr(8'd1, 1'b1, 0, 0, 0, stop);
    while (q.size() > 0) begin
      en = q.pop_front(); drive(en, got); n_tests++;
      if (got !== en.ex) begin n_fail++; $display("FAIL reset_post st=%0d got=%h exp=%h", en.ex.st, got, en.ex); end
    end
  endtask

  task automatic test_alu();
    ent_t en; obs_t got; bit stop;
    logic [7:0] ops [5];
    ops = '{8'd1, 8'd2, 8'd9, 8'd10, 8'd5};
    sel = 1'b0;
    do_reset();
    instr(8'd1, 1'b0, 0, 0, 0, stop);
    for (int i = 0; i < 5; i++)
      instr(ops[i], 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0, stop);
    while (q.size() > 0) begin
      en = q.pop_front(); drive(en, got); n_tests++;
      if (got !== en.ex) begin n_fail++; $display("FAIL alu st=%0d got=%h exp=%h", en.ex.st, got, en.ex); end
    end
  endtask

  task automatic test_jumpz();
    ent_t en; obs_t got; bit stop;
    sel = 1'b0;
    do_reset();
    instr(8'd4, 1'b0, 0, 0, 0, stop);
    instr(8'd4, 1'b1, 1, 0, 0, stop);
    instr(8'd3, 1'b0, 0, 0, 0, stop);
    instr(8'd4, 1'b0, 0, 0, 0, stop);
    while (q.size() > 0) begin
      en = q.pop_front(); drive(en, got); n_tests++;
      if (got !== en.ex) begin n_fail++; $display("FAIL jumpz st=%0d got=%h exp=%h", en.ex.st, got, en.ex); end
    end
  endtask

  task automatic test_store();
    ent_t en; obs_t got; bit stop;
    sel = 1'b0;
    do_reset();
    instr(8'd6, 1'b0, 0, 3, 0, stop);
    instr(8'd1, 1'b1, 20, 12, 0, stop);
    instr(8'd6, 1'b1, 0, 0, 0, stop);
    while (q.size() > 0) begin
      en = q.pop_front(); drive(en, got); n_tests++;
      if (got !== en.ex) begin n_fail++; $display("FAIL store st=%0d got=%h exp=%h", en.ex.st, got, en.ex); end
    end
  endtask

  task automatic test_timeout();
    ent_t en; obs_t got; bit stop;
    sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      case (k)
        0: instr(8'd1, 1'b0, 10, 0, 4, stop);
        1: begin
          instr(8'd1, 1'b0, 3, 0, 4, stop);
          instr(8'd2, 1'b0, 4, 4, 4, stop);
          instr(8'd6, 1'b0, 0, 9, 4, stop);
        end
        default: begin
          instr(8'd3, 1'b0, 4, 0, 4, stop);
          instr(8'd9, 1'b0, 0, 7, 4, stop);
        end
      endcase
      push_tail(5);
      while (q.size() > 0) begin
        en = q.pop_front(); drive(en, got); n_tests++;
        if (got !== en.ex) begin n_fail++; $display("FAIL timeout%0d st=%0d got=%h exp=%h", k, en.ex.st, got, en.ex); end
      end
    end
  endtask

  task automatic test_illegal_halt();
    ent_t en; obs_t got; bit stop;
    sel = 1'b0;
    do_reset();
    instr(8'd7, 1'b1, 0, 0, 0, stop);
    push_tail(6);
    while (q.size() > 0) begin
      en = q.pop_front(); drive(en, got); n_tests++;
      if (got !== en.ex) begin n_fail++; $display("FAIL illegal st=%0d got=%h exp=%h", en.ex.st, got, en.ex); end
    end
    do_reset();
    instr(8'd15, 1'b0, 1, 0, 0, stop);
    push_tail(20);
    while (q.size() > 0) begin
      en = q.pop_front(); drive(en, got); n_tests++;
      if (got !== en.ex) begin n_fail++; $display("FAIL halt st=%0d got=%h exp=%h", en.ex.st, got, en.ex); end
    end
  endtask

  task automatic test_random();
    ent_t en; obs_t got; bit stop;
    logic [7:0] legal [8];
    logic [7:0] op;
    int r;
    legal = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd9, 8'd10};
    for (int g = 0; g < 25; g++) begin
      sel = 1'($urandom);
      do_reset();
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 19);
        if (r < 16)      op = legal[r % 8];
        else if (r < 18) op = 8'd15;
        else             op = 8'($urandom);
        instr(op, 1'($urandom), $urandom_range(0, 6), $urandom_range(0, 6), sel ? 4 : 0, stop);
        if (stop) begin push_tail(3); break; end
      end
      while (q.size() > 0) begin
        en = q.pop_front(); drive(en, got); n_tests++;
        if (got !== en.ex) begin n_fail++; $display("FAIL random g%0d st=%0d got=%h exp=%h", g, en.ex.st, got, en.ex); end
      end
    end
  endtask

  initial begin
    Rst = 1'b0; MemReady = 1'b0; opcode = 8'd0; Zflag = 1'b0;
    sel = 1'b0; tc_m = 2'b00; mode_m = 0;
    test_reset();
    test_alu();
    test_jumpz();
    test_store();
    test_timeout();
    test_illegal_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ctr_mc.md
Name: ctr_mc

Overview:
Parametrised multicycle control FSM for the accumulator datapath (PC, MAR, MDR, IR, ACC, ALU, memory). Generalises the fixed fetch/decode/execute controller:
- Opcode and ALU-select widths are parameters.
- Memory accesses use a ready handshake with wait states and an optional timeout.
- Adds a HALT instruction, an illegal-opcode trap and an instruction-retire pulse.

Parameters:
OPW, 8, opcode width (>=4)
ALUW, 2, opALU width (>=2)
WAIT_LIMIT, 0, max consecutive not-ready memory cycles before bus trap; 0 = wait forever
OP_ADD, 1; OP_OR, 2; OP_JUMP, 3; OP_JUMPZ, 4; OP_LOAD, 5; OP_STORE, 6; OP_MULL, 9; OP_NEG, 10; OP_HALT, 15 — opcode encodings (OPW bits)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
Zflag  in  1  ACC zero flag
opcode  in  OPW  IR opcode field
MemReady  in  1  memory completes current access this cycle
muxPC, muxMAR, muxACC  out  1 each  datapath mux selects
loadMAR, loadPC, loadACC, loadMDR, loadIR  out  1 each  register load enables
opALU  out  ALUW  ALU op: 0 OR, 1 ADD, 2 MULL, 3 NEG
MemRW  out  1  1 = write
MemReq  out  1  memory access active
InstrDone  out  1  one-cycle retire pulse
Halted  out  1  in HALT state
TrapCause  out  2  00 none, 01 illegal opcode, 10 bus timeout (sticky)
state  out  4  current state, debug

Behaviour:
- States and encodings:
  - FETCH1=0, FETCH2=1, FETCH3=2, DECODE=3
  - EXEC1=4 (operand read), EXEC2=5 (ACC write)
  - STORE=6, JUMP=7, HALT=8, TRAP=9
  - 10-15 are unreachable; if entered, next state is TRAP with cause 01.
- Reset (Rst=0, async): state=FETCH1, op-class register=0, wait counter=0, TrapCause=00. While Rst=0 all outputs are 0. First active cycle after release is FETCH1.
- Output decode: Moore from state and op-class, except loadMDR and wait handling (below). Any output not listed for a state is 0.
  - FETCH1: loadMAR, loadPC.
  - FETCH2: MemReq; loadMDR=MemReady.
  - FETCH3: loadIR.
  - DECODE: muxMAR, loadMAR.
  - EXEC1: MemReq; loadMDR=MemReady.
  - EXEC2: loadACC. opALU per op-class (OR 0, ADD 1, MULL 2, NEG 3). LOAD class drives muxACC=1, opALU=0.
  - STORE: MemReq, MemRW.
  - JUMP: muxPC, loadPC.
  - HALT: Halted.
  - TRAP: none except TrapCause.
- Transitions:
  - FETCH1 -> FETCH2.
  - FETCH2 -> FETCH3 when MemReady, else stays in FETCH2.
  - FETCH3 -> DECODE.
  - DECODE latches op-class from opcode, then:
    - ADD/OR/MULL/NEG/LOAD -> EXEC1
    - STORE -> STORE
    - JUMP -> JUMP
    - JUMPZ: Zflag=1 -> JUMP; Zflag=0 -> FETCH1 with InstrDone=1 in DECODE
    - HALT -> HALT
    - any other value -> TRAP, TrapCause=01
  - EXEC1 -> EXEC2 when MemReady, else stays.
  - EXEC2 -> FETCH1, InstrDone=1.
  - STORE -> FETCH1 when MemReady (InstrDone=1 that cycle), else stays.
  - JUMP -> FETCH1, InstrDone=1.
  - HALT and TRAP are absorbing until reset.
- Wait counter:
  - Counts cycles with MemReq=1 and MemReady=0. Cleared whenever MemReady=1 or MemReq=0.
  - When WAIT_LIMIT>0 and the counter equals WAIT_LIMIT with MemReady still 0, next state is TRAP with TrapCause=10.
  - MemReady=1 in the same cycle the limit is reached wins: normal completion, no trap.
- TrapCause is written only on entry to TRAP; the first cause is kept.
- opALU: values zero-extended to ALUW.
- Opcode matching: compares all OPW bits.

Test Plan:
- Reset mid-EXEC1 (Rst low between edges) -> state=0 immediately, all outputs 0; after release FETCH1 outputs loadMAR=1, loadPC=1.
- ADD (opcode 1), MemReady always 1 -> state sequence 0,1,2,3,4,5,0; EXEC2 shows loadACC=1, opALU=1; InstrDone=1 only in EXEC2.
- JUMPZ (4) with Zflag=0 -> DECODE goes straight to FETCH1 with InstrDone=1 in DECODE. Zflag=1 -> JUMP with muxPC=1, loadPC=1.
- STORE (6), MemReady low 3 cycles then high, WAIT_LIMIT=0 -> STORE held 4 cycles with MemReq=MemRW=1; retire on 4th cycle.
- WAIT_LIMIT=4, MemReady stuck 0 in FETCH2 -> TRAP after 4 wait cycles, TrapCause=10. Repeat with MemReady=1 on the 4th cycle -> no trap.
- Opcode 7 -> TRAP, TrapCause=01. Opcode 15 -> HALT, Halted=1 held 20 cycles, no loads asserted.
